// File: rtl/clip_playback_if.sv
// Host/speaker-side bundle of clip_playback: load path, playback commands and sample stream.
interface clip_playback_if;
   logic               load_valid_in;
   logic signed [15:0] load_data_in;
   logic               load_clear_in;
   logic               start_in;
   logic               loop_in;
   logic               abort_in;
   logic               sample_tick_in;
   logic signed [15:0] sample_out;
   logic               sample_valid_out;
   logic               busy_out;
   logic               done_out;
   logic [15:0]        clip_len_out;
   logic               overflow_out;

   modport master (
      output load_valid_in, load_data_in, load_clear_in, start_in, loop_in, abort_in,
             sample_tick_in,
      input  sample_out, sample_valid_out, busy_out, done_out, clip_len_out, overflow_out
   );

   modport slave (
      input  load_valid_in, load_data_in, load_clear_in, start_in, loop_in, abort_in,
             sample_tick_in,
      output sample_out, sample_valid_out, busy_out, done_out, clip_len_out, overflow_out
   );
endinterface

// File: rtl/clip_playback.sv
// Clip store in dual-port BRAM, replayed one sample per tick; sample valid READ_LATENCY cycles after its tick.
// No backpressure: ticks are honoured in PLAY at up to one per clock, loads are taken only in IDLE.
module clip_playback #(
   parameter int RAM_DEPTH    = 48000,
   parameter int ADDR_WIDTH   = 16,
   parameter int READ_LATENCY = 2
) (
   input  logic          clk_in,
   input  logic          rst_in,
   clip_playback_if.slave bus
);
   localparam int                    MEM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH  = ADDR_WIDTH'(RAM_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PLAY  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]              state;
   logic [ADDR_WIDTH-1:0]   wr_ptr;
   logic [ADDR_WIDTH-1:0]   rd_ptr;
   logic [READ_LATENCY-1:0] vld_pipe;
   logic [READ_LATENCY:0]   vld_chain;
   logic signed [15:0]      mem [RAM_DEPTH];
   logic signed [15:0]      dat_pipe [READ_LATENCY];
   logic                    overflow;
   logic                    done;
   logic                    is_idle;
   logic                    wr_en;
   logic                    rd_en;
   logic                    busy_abort;
   logic                    last_addr;

   always_comb begin
      is_idle    = (state == ST_IDLE);
      wr_en      = is_idle && !bus.load_clear_in && bus.load_valid_in && (wr_ptr < DEPTH);
      rd_en      = (state == ST_PLAY) && bus.sample_tick_in && !bus.abort_in;
      busy_abort = !is_idle && bus.abort_in;
      last_addr  = (rd_ptr == wr_ptr - ADDR_WIDTH'(1));
      vld_chain  = {vld_pipe, rd_en};
   end

   // Port A: write-only load path.
   always_ff @(posedge clk_in) begin
      if (wr_en)
         mem[wr_ptr[MEM_AW-1:0]] <= bus.load_data_in;
   end

   // Port B: read-only; each data stage advances together with its valid bit, so the
   // final stage is the sample register and holds its value between valids.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < READ_LATENCY; i++)
            dat_pipe[i] <= '0;
      end else begin
         if (rd_en)
            dat_pipe[0] <= mem[rd_ptr[MEM_AW-1:0]];
         for (int i = 1; i < READ_LATENCY; i++)
            if (vld_chain[i])
               dat_pipe[i] <= dat_pipe[i-1];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         vld_pipe <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done     <= 1'b0;
         vld_pipe <= vld_chain[READ_LATENCY-1:0];
         case (state)
            ST_IDLE: begin
               if (bus.load_clear_in) begin
                  wr_ptr   <= '0;
                  overflow <= 1'b0;
               end else if (bus.load_valid_in) begin
                  if (wr_ptr < DEPTH)
                     wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                  else
                     overflow <= 1'b1;
               end
               if (bus.start_in) begin
                  if (wr_ptr != '0) begin
                     state  <= ST_PLAY;
                     rd_ptr <= '0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_PLAY: begin
               if (rd_en) begin
                  if (last_addr) begin
                     if (bus.loop_in)
                        rd_ptr <= '0;
                     else
                        state <= ST_DRAIN;
                  end else begin
                     rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                  end
               end
            end
            ST_DRAIN: begin
               // Leave when the pipe will be empty next cycle so done lands right after the last valid.
               if (vld_chain[READ_LATENCY-1:0] == '0) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (busy_abort) begin
            state    <= ST_IDLE;
            vld_pipe <= '0;
            done     <= 1'b1;
         end
      end
   end

   assign bus.sample_out       = dat_pipe[READ_LATENCY-1];
   assign bus.sample_valid_out = vld_chain[READ_LATENCY];
   assign bus.busy_out         = !is_idle;
   assign bus.done_out         = done;
   assign bus.clip_len_out     = 16'(wr_ptr);
   assign bus.overflow_out     = overflow;
endmodule
